// File: rtl/enc83_pkg.sv
// Shared constants, FSM state type and helpers for the 8-to-3 request encoder.
package enc83_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  localparam logic [W-1:0] StartFixed = W'(N - 1);

  typedef enum logic {IDLE, VALID} state_e;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  function automatic logic [W:0] popcount(input logic [N-1:0] vec);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, vec[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: searches downward from i_start with wrap-around.
module prio_enc8
  import enc83_pkg::*;
(
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_code,
  output logic         o_found
);

  logic [W-1:0] w_pos;

  always_comb begin
    o_code  = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      // W-bit subtraction wraps modulo N since N == 2**W
      w_pos = i_start - k[W-1:0];
      if (!o_found && i_mask[w_pos]) begin
        o_found = 1'b1;
        o_code  = w_pos;
      end
    end
  end

endmodule

// File: rtl/enc83_req_seq.sv
// Registered 8-to-3 request encoder with sticky pending vector and valid/ready output.
// Define ENC_RR_EN for round-robin priority instead of fixed highest-index priority.
module enc83_req_seq
  import enc83_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_idx,
  output logic [W:0]   o_pend_cnt,
  output logic         o_ovf
);

  state_e       r_state;
  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [W:0]   r_pend_cnt;
  logic         r_ovf;

  logic         w_accept;
  logic [N-1:0] w_rq;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_rem;
  logic [N-1:0] w_pend_next;
  logic [W-1:0] w_start_pend;
  logic [W-1:0] w_start_rem;
  logic [W-1:0] w_code_pend;
  logic [W-1:0] w_code_rem;
  logic         w_found_pend;
  logic         w_found_rem;

  assign w_accept    = r_valid && i_ready;
  assign w_rq        = i_req & {N{i_en}};
  assign w_clr       = w_accept ? onehot(r_idx) : '0;
  assign w_rem       = r_pending & ~w_clr;
  // Set wins over clear on the same bit
  assign w_pend_next = w_rem | w_rq;

`ifdef ENC_RR_EN
  logic [W-1:0] r_last;

  // The rem search only matters on accept, when last is about to become r_idx
  assign w_start_pend = r_last - 1'b1;
  assign w_start_rem  = r_idx - 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= '0;
    end else if (w_accept) begin
      r_last <= r_idx;
    end
  end
`else
  assign w_start_pend = StartFixed;
  assign w_start_rem  = StartFixed;
`endif

  prio_enc8 u_pe_pend (
    .i_mask  (r_pending),
    .i_start (w_start_pend),
    .o_code  (w_code_pend),
    .o_found (w_found_pend)
  );

  prio_enc8 u_pe_rem (
    .i_mask  (w_rem),
    .i_start (w_start_rem),
    .o_code  (w_code_rem),
    .o_found (w_found_rem)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_pend_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_pending  <= w_pend_next;
      r_pend_cnt <= popcount(w_pend_next);
      if (|(w_rq & w_rem)) begin
        r_ovf <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_found_pend) begin
            r_idx   <= w_code_pend;
            r_valid <= 1'b1;
            r_state <= VALID;
          end
        end
        VALID: begin
          if (i_ready) begin
            if (w_found_rem) begin
              r_idx <= w_code_rem;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_idx      = r_idx;
  assign o_pend_cnt = r_pend_cnt;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_enc83_req_seq.sv
// Scoreboard bench for enc83_req_seq: expected codes are queued by stimulus, popped on accept.
module tb_enc83_req_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic [7:0] i_req;
  logic       i_ready;
  logic       o_valid;
  logic [2:0] o_idx;
  logic [3:0] o_pend_cnt;
  logic       o_ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  enc83_req_seq dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_req      (i_req),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_idx      (o_idx),
    .o_pend_cnt (o_pend_cnt),
    .o_ovf      (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic samp();
    @(negedge i_clk);
  endtask

  // Monitor: every accepted code is compared against the head of the queue
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_code", int'(o_idx), -1);
      end else begin
        chk("code", int'(o_idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_req = '0; i_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    samp();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_idx", int'(o_idx), 0);
    chk("rst_cnt", int'(o_pend_cnt), 0);
    chk("rst_ovf", int'(o_ovf), 0);

    // 1: idle drain
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); samp();
      chk("idle_valid", int'(o_valid), 0);
      chk("idle_cnt", int'(o_pend_cnt), 0);
    end

    // 2: single request, two-edge latency
    tick();
    exp_q.push_back(2);
    i_req = 8'b0000_0100;
    tick(); i_req = '0;
    samp();
    chk("single_cnt1", int'(o_pend_cnt), 1);
    chk("single_valid_early", int'(o_valid), 0);
    tick(); samp();
    chk("single_valid", int'(o_valid), 1);
    chk("single_idx", int'(o_idx), 2);
    tick(); samp();
    chk("single_done_valid", int'(o_valid), 0);
    chk("single_done_cnt", int'(o_pend_cnt), 0);

    // 3: priority drain 7,5,1
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(1);
    i_req = 8'b1010_0010;
    tick(); i_req = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); samp();
      chk("drain_cnt", int'(o_pend_cnt), 3 - i);
    end
    tick(); samp();
    chk("drain_valid", int'(o_valid), 0);
    chk("drain_cnt0", int'(o_pend_cnt), 0);

    // 4: stall holds idx even when a higher line arrives
    i_ready = 1'b0;
    i_req = 8'b0000_1001;
    tick(); i_req = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); samp();
      chk("stall_valid", int'(o_valid), 1);
      chk("stall_idx", int'(o_idx), 3);
    end
    i_req = 8'b0100_0000;
    tick(); i_req = '0;
    tick(); samp();
    chk("stall_hi_idx", int'(o_idx), 3);
    chk("stall_hi_cnt", int'(o_pend_cnt), 3);
    chk("stall_ovf", int'(o_ovf), 0);
    exp_q.push_back(3); exp_q.push_back(6); exp_q.push_back(0);
    i_ready = 1'b1;
    tick(); tick(); tick(); samp();
    chk("stall_end_valid", int'(o_valid), 0);

    // 5: overflow, then set-wins on the accepted line
    i_ready = 1'b0;
    i_req = 8'b1000_0100;
    tick(); i_req = '0;
    tick(); samp();
    chk("ovf_pre", int'(o_ovf), 0);
    chk("ovf_idx", int'(o_idx), 7);
    i_req = 8'b0000_0100;
    tick(); i_req = '0;
    samp();
    chk("ovf_set", int'(o_ovf), 1);
    chk("ovf_cnt", int'(o_pend_cnt), 2);
    i_req = 8'b0010_0000;
    tick(); i_req = '0;
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(5);
    i_ready = 1'b1;
    tick();
    samp();
    chk("sw_idx5", int'(o_idx), 5);
    i_req = 8'b0010_0000;
    tick(); i_req = '0;
    samp();
    chk("sw_cnt", int'(o_pend_cnt), 2);
    tick(); tick(); samp();
    chk("sw_valid", int'(o_valid), 0);
    chk("sw_ovf_sticky", int'(o_ovf), 1);
    chk("sw_cnt0", int'(o_pend_cnt), 0);

    // 6: enable gating and reset mid-operation
    i_ready = 1'b0;
    i_en = 1'b0; i_req = 8'hFF;
    tick(); tick(); samp();
    chk("en_valid", int'(o_valid), 0);
    chk("en_cnt", int'(o_pend_cnt), 0);
    i_en = 1'b1;
    tick(); i_req = '0;
    tick(); samp();
    chk("ff_valid", int'(o_valid), 1);
    chk("ff_idx", int'(o_idx), 7);
    chk("ff_cnt", int'(o_pend_cnt), 8);
    i_rst = 1'b1;
    tick(); samp();
    chk("mrst_valid", int'(o_valid), 0);
    chk("mrst_cnt", int'(o_pend_cnt), 0);
    chk("mrst_ovf", int'(o_ovf), 0);
    chk("mrst_idx", int'(o_idx), 0);
    i_rst = 1'b0;
    tick(); samp();
    chk("post_valid", int'(o_valid), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
